// File: rtl/uart_tx_queue_pkg.sv
// Shared IO decode constants and UART status bit positions for the SOC slice.
// Used by the UART transmit queue and the IO read mux.
package uart_tx_queue_pkg;

    localparam int IO_LEDS_bit      = 0;
    localparam int IO_UART_DAT_bit  = 1;
    localparam int IO_UART_CNTL_bit = 2;

    localparam int UART_STAT_FULL_bit   = 9;
    localparam int UART_STAT_ACTIVE_bit = 8;
    localparam int UART_STAT_OVF_bit    = 31;

    // One-hot word address bit -> byte offset within the IO page.
    function automatic logic [31:0] io_bit_to_offset(input int bit_idx);
        return 32'(1) << (bit_idx + 2);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with wrap-bit pointers; head word is visible combinationally.
// Latency: push to rd_data/!empty is 1 clk. Caller must not push when full unless popping.
module sync_fifo_fwft #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  pop,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic [DATA_W-1:0]   mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage deliberately has no reset so it maps onto LUT RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    // count never exceeds DEPTH, so its MSB alone marks full.
    assign full    = count[DEPTH_LOG2];

endmodule

// File: rtl/uart_tx_queue.sv
// Buffers CPU UART byte writes and drains them into the emitter over valid/ready; formats CNTL status.
// Latency: write to tx_valid 1 clk. Backpressure: tx_ready low holds the head; writes to a full queue drop and set sticky overflow.
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flush,
    output logic [31:0]       status,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    logic                empty;
    logic                full;
    logic [DEPTH_LOG2:0] count;
    logic                handshake;
    logic                push;
    logic                pop;
    logic                overflow;

    assign tx_valid  = !empty;
    assign handshake = tx_valid & tx_ready;
    // Flush wins over both sides: the incoming byte is lost and the head is not consumed.
    assign pop       = handshake & !flush;
    assign push      = wr_en & (!full | handshake) & !flush;

    sync_fifo_fwft #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (flush),
        .push    (push),
        .wr_data (wr_data),
        .pop     (pop),
        .rd_data (tx_data),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            overflow <= 1'b0;
        end else if (wr_en && full && !handshake) begin
            overflow <= 1'b1;
        end
    end

    always_comb begin
        status                       = '0;
        status[DEPTH_LOG2:0]         = count;
        status[UART_STAT_ACTIVE_bit] = !empty | !tx_ready;
        status[UART_STAT_FULL_bit]   = full;
        status[UART_STAT_OVF_bit]    = overflow;
    end

endmodule
